// File: rtl/aes_dp_ctrl.sv
// Handshake controller around an iterative AES datapath: loads a block, runs the
// datapath until its final-round flag (or a timeout), then holds the result for the consumer.
module aes_dp_ctrl #(
    parameter int unsigned RND_SIZE = 128,
    parameter int unsigned TMO_CYC  = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [RND_SIZE-1:0] s_text,
    input  logic [RND_SIZE-1:0] s_key,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [RND_SIZE-1:0] m_data,
    output logic                dp_en,
    output logic [RND_SIZE-1:0] dp_text,
    output logic [RND_SIZE-1:0] dp_key,
    input  logic [RND_SIZE-1:0] dp_cypher,
    input  logic                dp_flag,
    output logic                o_busy,
    output logic                o_err,
    output logic [CNT_W-1:0]    o_blk_cnt
);

    localparam int unsigned TMR_W = $clog2(TMO_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DONE,
        ERR
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] tmr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tmr       <= '0;
            m_valid   <= 1'b0;
            dp_en     <= 1'b0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
            o_blk_cnt <= '0;
            m_data    <= '0;
            dp_text   <= '0;
            dp_key    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        dp_text <= s_text;
                        dp_key  <= s_key;
                        o_busy  <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    tmr   <= '0;
                    dp_en <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    // The final-round flag wins over a timeout landing in the same cycle.
                    if (dp_flag) begin
                        m_data  <= dp_cypher;
                        m_valid <= 1'b1;
                        dp_en   <= 1'b0;
                        state   <= DONE;
                    end else if (tmr == TMR_W'(TMO_CYC - 1)) begin
                        o_err <= 1'b1;
                        dp_en <= 1'b0;
                        state <= ERR;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        o_blk_cnt <= o_blk_cnt + CNT_W'(1);
                        m_valid   <= 1'b0;
                        o_busy    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                ERR: state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rst so the input side reads not-ready while reset is held.
    assign s_ready = (state == IDLE) && !rst;

endmodule

// File: tb/tb_aes_dp_ctrl.sv
// Self-checking bench for aes_dp_ctrl with a behavioural datapath model that raises
// its final-round flag after a chosen number of enabled cycles.
module tb_aes_dp_ctrl;

    localparam int RS  = 128;
    localparam int TMO = 15;
    localparam int CW  = 2;

    localparam logic [127:0] SPEC_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SPEC_T = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] SPEC_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, m_valid, m_ready, dp_en, dp_flag, o_busy, o_err;
    logic [RS-1:0] s_text, s_key, m_data, dp_text, dp_key, dp_cypher;
    logic [CW-1:0] o_blk_cnt;

    int total = 0;
    int bad = 0;
    int blocks_done = 0;
    int low_streak = 0;

    always #5 clk = ~clk;

    aes_dp_ctrl #(.RND_SIZE(RS), .TMO_CYC(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_text(s_text), .s_key(s_key),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .dp_en(dp_en), .dp_text(dp_text), .dp_key(dp_key),
        .dp_cypher(dp_cypher), .dp_flag(dp_flag),
        .o_busy(o_busy), .o_err(o_err), .o_blk_cnt(o_blk_cnt)
    );

    function automatic logic [127:0] cipher(input logic [127:0] t, input logic [127:0] k);
        if (t == SPEC_T && k == SPEC_K) return SPEC_C;
        return t ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Datapath model: flags once it has completed flag_at enabled cycles.
    int            en_cnt = 0;
    int            flag_at = 11;
    logic          force_flag = 1'b0;
    logic [RS-1:0] noise = '0;
    logic          model_flag;

    always @(posedge clk) en_cnt <= dp_en ? en_cnt + 1 : 0;
    always @(negedge clk) noise <= rnd128();
    assign model_flag = dp_en && (en_cnt == flag_at);
    assign dp_flag    = model_flag || force_flag;
    assign dp_cypher  = model_flag ? cipher(dp_text, dp_key) : noise;

    function automatic logic [CW-1:0] exp_cnt();
        return CW'(blocks_done % (1 << CW));
    endfunction

    task automatic track(inout bit got, inout int gap);
        if (dp_en) begin
            if (!got) begin gap = low_streak; got = 1; end
            low_streak = 0;
        end else begin
            low_streak++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; force_flag = 1'b0;
        @(negedge clk); rst = 1'b0;
        blocks_done = 0;
    endtask

    task automatic run_block(input logic [127:0] text, input logic [127:0] key, input int fa,
                             input int hold, input bit noisy, output int lat, output int en_cyc,
                             output int gap, output bit unstable, output bit held_bad,
                             output logic [127:0] data);
        logic [CW-1:0] cnt0;
        bit got;
        lat = -1; en_cyc = 0; gap = -1; unstable = 0; held_bad = 0; data = '0; got = 0;
        flag_at = fa; m_ready = 1'b0;
        @(negedge clk); track(got, gap);
        s_valid = 1'b1; s_text = text; s_key = key;
        for (int i = 0; i < 20 && !s_ready; i++) begin @(negedge clk); track(got, gap); end
        @(negedge clk);
        s_valid = 1'b0; s_text = rnd128(); s_key = rnd128();
        for (int i = 1; i <= 40; i++) begin
            track(got, gap);
            if (dp_en) en_cyc++;
            if (dp_text !== text || dp_key !== key) unstable = 1;
            if (m_valid) begin lat = i; break; end
            @(negedge clk);
        end
        if (lat < 0) return;
        data = m_data; cnt0 = o_blk_cnt; force_flag = noisy;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); track(got, gap);
            if (!m_valid || m_data !== data || s_ready || o_blk_cnt !== cnt0 || dp_text !== text)
                held_bad = 1;
        end
        force_flag = 1'b0; m_ready = 1'b1;
        @(negedge clk); track(got, gap);
        m_ready = 1'b0;
        blocks_done++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
        total++; if ({m_valid, dp_en, o_busy, o_err} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%b want=0000", {m_valid, dp_en, o_busy, o_err}); end
        total++; if (o_blk_cnt !== '0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", o_blk_cnt); end
        total++; if ((m_data | dp_text | dp_key) !== '0) begin bad++; $display("FAIL rst_data got=%h/%h/%h want=0", m_data, dp_text, dp_key); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (s_ready !== 1'b1 || o_busy !== 1'b0) begin bad++; $display("FAIL rst_idle got s_ready=%b busy=%b want 1/0", s_ready, o_busy); end
    endtask

    task automatic test_vector();
        int lat, en_cyc, gap; bit unst, hb; logic [127:0] d;
        run_block(SPEC_T, SPEC_K, 11, 0, 0, lat, en_cyc, gap, unst, hb, d);
        total++; if (lat !== 14) begin bad++; $display("FAIL vec_latency got=%0d want=14", lat); end
        total++; if (d !== SPEC_C) begin bad++; $display("FAIL vec_data got=%h want=%h", d, SPEC_C); end
        total++; if (en_cyc !== 12 || unst) begin bad++; $display("FAIL vec_run got en=%0d unstable=%0d want 12/0", en_cyc, unst); end
        total++; if (o_blk_cnt !== exp_cnt()) begin bad++; $display("FAIL vec_cnt got=%0d want=%0d", o_blk_cnt, exp_cnt()); end
    endtask

    task automatic test_backpressure();
        int lat, en_cyc, gap, fa; bit unst, hb; logic [127:0] t, k, d;
        t = rnd128(); k = rnd128(); fa = $urandom_range(14, 1);
        run_block(t, k, fa, 5, 1, lat, en_cyc, gap, unst, hb, d);
        total++; if (hb) begin bad++; $display("FAIL bp_hold got=held_bad want=held_ok"); end
        total++; if (lat !== 3 + fa || d !== cipher(t, k)) begin bad++; $display("FAIL bp_result got lat=%0d d=%h want %0d/%h", lat, d, 3 + fa, cipher(t, k)); end
        total++; if (o_blk_cnt !== exp_cnt() || m_valid !== 1'b0) begin bad++; $display("FAIL bp_accept got cnt=%0d mv=%b want %0d/0", o_blk_cnt, m_valid, exp_cnt()); end
    endtask

    task automatic test_random();
        int lat, en_cyc, gap, fa; bit unst, hb; logic [127:0] t, k, d;
        for (int n = 0; n < 6; n++) begin
            t = rnd128(); k = rnd128(); fa = $urandom_range(14, 1);
            run_block(t, k, fa, $urandom_range(3, 0), 0, lat, en_cyc, gap, unst, hb, d);
            total++; if (lat !== 3 + fa || d !== cipher(t, k) || en_cyc !== fa + 1 || unst || hb)
                begin bad++; $display("FAIL rand_blk%0d got lat=%0d en=%0d d=%h want %0d/%0d/%h", n, lat, en_cyc, d, 3 + fa, fa + 1, cipher(t, k)); end
            total++; if (o_blk_cnt !== exp_cnt()) begin bad++; $display("FAIL rand_cnt%0d got=%0d want=%0d", n, o_blk_cnt, exp_cnt()); end
        end
    endtask

    task automatic test_flag_boundary();
        int lat, en_cyc, gap; bit unst, hb; logic [127:0] t, k, d;
        t = rnd128(); k = rnd128();
        run_block(t, k, TMO - 1, 0, 0, lat, en_cyc, gap, unst, hb, d);
        total++; if (lat !== 3 + TMO - 1 || d !== cipher(t, k) || en_cyc !== TMO) begin bad++; $display("FAIL flag_last got lat=%0d en=%0d want %0d/%0d", lat, en_cyc, 2 + TMO, TMO); end
        total++; if (o_err !== 1'b0 || o_blk_cnt !== exp_cnt()) begin bad++; $display("FAIL flag_last_err got err=%b cnt=%0d want 0/%0d", o_err, o_blk_cnt, exp_cnt()); end
        run_block(t, k, 1, 0, 0, lat, en_cyc, gap, unst, hb, d);
        total++; if (lat !== 4 || d !== cipher(t, k)) begin bad++; $display("FAIL flag_min got lat=%0d want 4", lat); end
    endtask

    task automatic test_ignore();
        logic [127:0] d0;
        logic [CW-1:0] c0;
        d0 = m_data; c0 = o_blk_cnt;
        @(negedge clk); force_flag = 1'b1; m_ready = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (m_valid !== 1'b0 || o_busy !== 1'b0 || dp_en !== 1'b0) begin bad++; $display("FAIL ign_state got mv=%b busy=%b en=%b want 000", m_valid, o_busy, dp_en); end
        total++; if (o_blk_cnt !== c0 || m_data !== d0) begin bad++; $display("FAIL ign_hold got cnt=%0d want=%0d", o_blk_cnt, c0); end
        force_flag = 1'b0; m_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int lat, en_cyc, gap; bit unst, hb, stuck; logic [127:0] d;
        run_block(rnd128(), rnd128(), TMO, 0, 0, lat, en_cyc, gap, unst, hb, d);
        total++; if (lat !== -1 || en_cyc !== TMO) begin bad++; $display("FAIL tmo_run got lat=%0d en=%0d want -1/%0d", lat, en_cyc, TMO); end
        total++; if (o_err !== 1'b1 || s_ready !== 1'b0 || o_busy !== 1'b1 || m_valid !== 1'b0) begin bad++; $display("FAIL tmo_err got err=%b rdy=%b busy=%b mv=%b want 1010", o_err, s_ready, o_busy, m_valid); end
        s_valid = 1'b1; m_ready = 1'b1; force_flag = 1'b1; stuck = 1;
        repeat (5) begin
            @(negedge clk);
            if (o_err !== 1'b1 || s_ready !== 1'b0 || o_busy !== 1'b1 || m_valid !== 1'b0 || dp_en !== 1'b0) stuck = 0;
        end
        total++; if (!stuck) begin bad++; $display("FAIL tmo_absorb got=left_err want=stay_err"); end
        do_reset();
        @(negedge clk);
        total++; if (o_err !== 1'b0 || s_ready !== 1'b1 || o_blk_cnt !== '0 || o_busy !== 1'b0) begin bad++; $display("FAIL tmo_clear got err=%b rdy=%b cnt=%0d want 0/1/0", o_err, s_ready, o_blk_cnt); end
    endtask

    task automatic test_back_to_back();
        int lat, en_cyc, gap, fa; bit unst, hb; logic [127:0] t, k, d;
        int want_seq [5] = '{1, 2, 3, 0, 1};
        do_reset();
        for (int n = 0; n < 5; n++) begin
            t = rnd128(); k = rnd128(); fa = $urandom_range(12, 1);
            run_block(t, k, fa, 0, 0, lat, en_cyc, gap, unst, hb, d);
            total++; if (o_blk_cnt !== CW'(want_seq[n]) || o_blk_cnt !== exp_cnt()) begin bad++; $display("FAIL b2b_cnt%0d got=%0d want=%0d", n, o_blk_cnt, want_seq[n]); end
            total++; if (lat !== 3 + fa || d !== cipher(t, k)) begin bad++; $display("FAIL b2b_data%0d got lat=%0d d=%h want %0d/%h", n, lat, d, 3 + fa, cipher(t, k)); end
            if (n > 0) begin
                total++; if (gap < 2) begin bad++; $display("FAIL b2b_gap%0d got=%0d want>=2", n, gap); end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, en_cyc, gap, runs; bit unst, hb, spurious; logic [127:0] t, k, d;
        flag_at = 11; runs = 0;
        @(negedge clk); s_valid = 1'b1; s_text = rnd128(); s_key = rnd128();
        @(negedge clk); s_valid = 1'b0;
        for (int i = 0; i < 20 && runs < 5; i++) begin
            @(negedge clk);
            if (dp_en) runs++;
        end
        total++; if (runs !== 5) begin bad++; $display("FAIL mid_reach got=%0d want=5", runs); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        blocks_done = 0;
        total++; if (dp_en !== 1'b0 || m_valid !== 1'b0 || o_blk_cnt !== '0 || o_busy !== 1'b0) begin bad++; $display("FAIL mid_rst got en=%b mv=%b cnt=%0d busy=%b want 0/0/0/0", dp_en, m_valid, o_blk_cnt, o_busy); end
        spurious = 0;
        repeat (20) begin @(negedge clk); if (m_valid !== 1'b0 || dp_en !== 1'b0) spurious = 1; end
        total++; if (spurious) begin bad++; $display("FAIL mid_quiet got=activity want=none"); end
        t = rnd128(); k = rnd128();
        run_block(t, k, 7, 0, 0, lat, en_cyc, gap, unst, hb, d);
        total++; if (lat !== 10 || d !== cipher(t, k) || o_blk_cnt !== CW'(1)) begin bad++; $display("FAIL mid_next got lat=%0d cnt=%0d d=%h want 10/1/%h", lat, o_blk_cnt, d, cipher(t, k)); end
    endtask

    initial begin
        s_valid = 1'b0; m_ready = 1'b0; s_text = '0; s_key = '0;
        test_reset();
        test_vector();
        test_backpressure();
        test_random();
        test_flag_boundary();
        test_ignore();
        test_timeout();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
